// File: rtl/btn_conditioner_if.sv
// Button conditioner bundle: raw pads in, conditioned button state out.
//   btn_raw     : asynchronous raw buttons, active high (driven by master)
//   btn_level   : debounced level with stuck buttons masked
//   btn_press   : one-cycle pulse on a stable rising level
//   btn_release : one-cycle pulse on a stable falling level
//   btn_stuck   : per-button stuck flag
//   any_press   : OR of btn_press
interface btn_conditioner_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;
    logic [WIDTH-1:0] btn_stuck;
    logic             any_press;

    // Pad / stimulus side
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_stuck,
        input  any_press
    );

    // Conditioner side
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_stuck,
        output any_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button input conditioner: two-flop synchronizer, consecutive-sample debouncer,
// registered press/release pulses and a stuck-button detector that masks the level.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : btn_conditioner_if slave (btn_raw in; level/press/release/stuck/any_press out)
module btn_conditioner #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_LIMIT      = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    btn_conditioner_if.slave bus
);

    localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam bit               HoldEn  = (HOLD_LIMIT != 0);
    localparam logic [15:0]      HoldMax = 16'((HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] stuck_q, stuck_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [15:0]      hold_q [WIDTH];
    logic [15:0]      hold_d [WIDTH];

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        stuck_d   = stuck_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i]  = '0;
            hold_d[i] = hold_q[i];

            // Debounce: only an unbroken run of mismatching samples flips the level.
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            // Stuck detection: count stable-high cycles; a falling level clears everything
            // on the same edge as the release pulse.
            if (!level_q[i] || !level_d[i]) begin
                hold_d[i]  = '0;
                stuck_d[i] = 1'b0;
            end else if (HoldEn && !stuck_q[i]) begin
                if (hold_q[i] == HoldMax) begin
                    stuck_d[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            stuck_q   <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            s1_q      <= bus.btn_raw;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            stuck_q   <= stuck_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign bus.btn_level   = level_q & ~stuck_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_stuck   = stuck_q;
    assign bus.any_press   = |press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4, HOLD_LIMIT=20).
// Expected output vectors are queued per edge index before stimulus runs and
// compared 1 ns after each rising edge.
module tb_btn_conditioner;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    btn_conditioner_if #(.WIDTH(W)) bus ();

    btn_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4),
        .HOLD_LIMIT     (20)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        string      tag;
        logic [7:0] lvl;
        logic [7:0] prs;
        logic [7:0] rls;
        logic [7:0] stk;
    } exp_t;

    exp_t sb[$];
    int   rel;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_range(input int from, input int to, input string tag,
                                input logic [7:0] lvl, input logic [7:0] prs,
                                input logic [7:0] rls, input logic [7:0] stk);
        exp_t x;
        for (int e = from; e <= to; e++) begin
            x.e   = e;
            x.tag = tag;
            x.lvl = lvl;
            x.prs = prs;
            x.rls = rls;
            x.stk = stk;
            sb.push_back(x);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " lvl"}, 32'(bus.btn_level), 32'h0);
        check_eq({tag, " prs"}, 32'(bus.btn_press), 32'h0);
        check_eq({tag, " rls"}, 32'(bus.btn_release), 32'h0);
        check_eq({tag, " stk"}, 32'(bus.btn_stuck), 32'h0);
        check_eq({tag, " any"}, 32'(bus.any_press), 32'h0);
    endtask

    // Advance one rising edge and compare every expectation due at that edge.
    task automatic step();
        exp_t x;
        @(posedge clk);
        #1;
        rel++;
        while (sb.size() > 0 && sb[0].e <= rel) begin
            x = sb.pop_front();
            check_eq($sformatf("%s@%0d lvl", x.tag, x.e), 32'(bus.btn_level), 32'(x.lvl));
            check_eq($sformatf("%s@%0d prs", x.tag, x.e), 32'(bus.btn_press), 32'(x.prs));
            check_eq($sformatf("%s@%0d rls", x.tag, x.e), 32'(bus.btn_release), 32'(x.rls));
            check_eq($sformatf("%s@%0d stk", x.tag, x.e), 32'(bus.btn_stuck), 32'(x.stk));
            check_eq($sformatf("%s@%0d any", x.tag, x.e), 32'(bus.any_press),
                     32'(|x.prs));
        end
    endtask

    task automatic end_scenario(input string tag);
        check_eq({tag, " sb_empty"}, 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    // Leaves rel = -1 so the next rising edge is edge 0 of the scenario.
    task automatic do_reset();
        rst_n       = 1'b0;
        bus.btn_raw = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel   = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_raw = '0;
        rel         = -1;
        #1;
        check_all_zero("reset_hold");
        do_reset();
        check_all_zero("reset_release");

        // Clean press on bit 2
        expect_range(0, 4, "press2", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(5, 5, "press2", 8'h04, 8'h04, 8'h00, 8'h00);
        expect_range(6, 8, "press2", 8'h04, 8'h00, 8'h00, 8'h00);
        for (int e = 0; e <= 8; e++) begin
            bus.btn_raw = 8'h04;
            step();
        end
        end_scenario("press2");

        // Bounce on bit 0, settling high from edge 12
        do_reset();
        expect_range(0, 16, "bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(17, 17, "bounce", 8'h01, 8'h01, 8'h00, 8'h00);
        expect_range(18, 22, "bounce", 8'h01, 8'h00, 8'h00, 8'h00);
        for (int e = 0; e <= 22; e++) begin
            bus.btn_raw = (e < 12) ? {7'd0, (((e / 2) % 2) == 0)} : 8'h01;
            step();
        end
        end_scenario("bounce");

        // Three-cycle glitch on bit 5 must never reach the outputs
        do_reset();
        expect_range(0, 15, "glitch", 8'h00, 8'h00, 8'h00, 8'h00);
        for (int e = 0; e <= 15; e++) begin
            bus.btn_raw = (e < 3) ? 8'h20 : 8'h00;
            step();
        end
        end_scenario("glitch");

        // Simultaneous press and release on bits 0 and 7
        do_reset();
        expect_range(0, 4, "multi", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(5, 5, "multi", 8'h81, 8'h81, 8'h00, 8'h00);
        expect_range(6, 14, "multi", 8'h81, 8'h00, 8'h00, 8'h00);
        expect_range(15, 15, "multi", 8'h00, 8'h00, 8'h81, 8'h00);
        expect_range(16, 18, "multi", 8'h00, 8'h00, 8'h00, 8'h00);
        for (int e = 0; e <= 18; e++) begin
            bus.btn_raw = (e < 10) ? 8'h81 : 8'h00;
            step();
        end
        end_scenario("multi");

        // Stuck bit 3, release, then a fresh press that must count from zero again
        do_reset();
        expect_range(0, 4, "stuck", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(5, 5, "stuck", 8'h08, 8'h08, 8'h00, 8'h00);
        expect_range(6, 24, "stuck", 8'h08, 8'h00, 8'h00, 8'h00);
        expect_range(25, 34, "stuck", 8'h00, 8'h00, 8'h00, 8'h08);
        expect_range(35, 35, "stuck", 8'h00, 8'h00, 8'h08, 8'h00);
        expect_range(36, 44, "stuck", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(45, 45, "stuck", 8'h08, 8'h08, 8'h00, 8'h00);
        expect_range(46, 64, "stuck", 8'h08, 8'h00, 8'h00, 8'h00);
        expect_range(65, 66, "stuck", 8'h00, 8'h00, 8'h00, 8'h08);
        for (int e = 0; e <= 66; e++) begin
            bus.btn_raw = (e < 30 || e >= 40) ? 8'h08 : 8'h00;
            step();
        end
        end_scenario("stuck");

        // Reset while bit 6 is qualified and bit 1 is mid-debounce
        do_reset();
        expect_range(0, 4, "rstmid", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(5, 5, "rstmid", 8'h40, 8'h40, 8'h00, 8'h00);
        expect_range(6, 12, "rstmid", 8'h40, 8'h00, 8'h00, 8'h00);
        for (int e = 0; e <= 12; e++) begin
            bus.btn_raw = (e < 9) ? 8'h40 : 8'h42;
            step();
        end
        end_scenario("rstmid_pre");
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid_async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rstmid_held");
        rst_n = 1'b1;
        rel   = -1;
        expect_range(0, 4, "requal", 8'h00, 8'h00, 8'h00, 8'h00);
        expect_range(5, 5, "requal", 8'h42, 8'h42, 8'h00, 8'h00);
        expect_range(6, 7, "requal", 8'h42, 8'h00, 8'h00, 8'h00);
        while (rel < 7) step();
        end_scenario("requal");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
